// File: rtl/exception_unit.sv
// Commit-point exception/ERET arbiter: prioritises events, pulses CP0 update and flush,
// then holds a fetch redirect until acknowledged. Optional macro: EXC_TLB_REFILL_VEC_EN.
module exception_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic [10:0] commit_exc,
  input  logic        commit_store,
  input  logic        commit_eret,
`ifdef EXC_TLB_REFILL_VEC_EN
  input  logic        mem_tlb_refill,
`endif
  input  logic [31:0] mem_vaddr,
  input  logic [7:0]  interrupt_flag,
  input  logic        allow_interrupt,
  input  logic        exl_set,
  input  logic        use_special_iv,
  input  logic        use_bootstrap_iv,
  input  logic [31:0] ebase_address,
  input  logic [31:0] epc_address,
  input  logic        redirect_ack,
  output logic        exp_en,
  output logic        exp_bd,
  output logic        exp_badvaddr_en,
  output logic        exl_clean,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic [31:0] exp_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  logic [0:0]  state;
  logic        intr;
  logic        ev;
  logic        is_eret;
  logic        fetch_fault;
  logic        data_fault;
  logic        refill;
  logic [4:0]  code;
  logic [31:0] vec_base;
  logic [31:0] vec_off;
  logic [31:0] epc_calc;

  assign intr = allow_interrupt & (|interrupt_flag);

  always_comb begin
    ev          = 1'b1;
    is_eret     = 1'b0;
    fetch_fault = 1'b0;
    data_fault  = 1'b0;
    refill      = 1'b0;
    code        = 5'd0;
    if (intr) begin
      code = 5'd0;
    end else if (commit_exc[0]) begin
      code = 5'd4; fetch_fault = 1'b1;
    end else if (commit_exc[1] | commit_exc[2]) begin
      code = 5'd2; fetch_fault = 1'b1; refill = commit_exc[1];
    end else if (commit_exc[3]) begin
      code = 5'd10;
    end else if (commit_exc[4]) begin
      code = 5'd11;
    end else if (commit_exc[5]) begin
      code = 5'd12;
    end else if (commit_exc[6]) begin
      code = 5'd8;
    end else if (commit_exc[7]) begin
      code = 5'd9;
    end else if (commit_exc[8]) begin
      code = 5'd4; data_fault = 1'b1;
    end else if (commit_exc[9]) begin
      code = 5'd5; data_fault = 1'b1;
    end else if (commit_exc[10]) begin
      code = commit_store ? 5'd3 : 5'd2; data_fault = 1'b1;
`ifdef EXC_TLB_REFILL_VEC_EN
      refill = mem_tlb_refill;
`endif
    end else if (commit_eret) begin
      is_eret = 1'b1;
    end else begin
      ev = 1'b0;
    end
  end

  // Refill only gets its own vector when the feature is built in; otherwise it shares 0x180.
  always_comb begin
    vec_base = use_bootstrap_iv ? 32'hBFC0_0200 : ebase_address;
    vec_off  = 32'h0000_0180;
    if (intr && use_special_iv)
      vec_off = 32'h0000_0200;
`ifdef EXC_TLB_REFILL_VEC_EN
    else if (refill && !exl_set)
      vec_off = 32'h0000_0000;
`endif
    epc_calc = commit_bd ? (commit_pc - 32'd4) : commit_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      exp_en          <= 1'b0;
      flush           <= 1'b0;
      exl_clean       <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      exp_bd          <= 1'b0;
      exp_code        <= '0;
      exp_epc         <= '0;
      exp_badvaddr    <= '0;
      redirect_pc     <= '0;
    end else begin
      exp_en          <= 1'b0;
      flush           <= 1'b0;
      exl_clean       <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_valid && ev) begin
            state           <= REDIRECT;
            exp_en          <= 1'b1;
            flush           <= 1'b1;
            exl_clean       <= is_eret;
            exp_code        <= code;
            exp_bd          <= is_eret ? 1'b0 : commit_bd;
            exp_epc         <= is_eret ? epc_address : epc_calc;
            exp_badvaddr_en <= fetch_fault | data_fault;
            exp_badvaddr    <= fetch_fault ? commit_pc : mem_vaddr;
            redirect_pc     <= is_eret ? epc_address : (vec_base + vec_off);
          end
        end
        default: begin
          if (redirect_ack)
            state <= IDLE;
        end
      endcase
    end
  end

  assign redirect_valid = (state == REDIRECT);
  assign busy           = (state == REDIRECT);

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: a table-driven event model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_exception_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [10:0] commit_exc;
  logic        commit_store;
  logic        commit_eret;
  logic        mem_tlb_refill;
  logic [31:0] mem_vaddr;
  logic [7:0]  interrupt_flag;
  logic        allow_interrupt, exl_set, use_special_iv, use_bootstrap_iv;
  logic [31:0] ebase_address, epc_address;
  logic        redirect_ack;
  logic        exp_en, exp_bd, exp_badvaddr_en, exl_clean, flush, redirect_valid, busy;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_badvaddr, redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_bd(commit_bd), .commit_exc(commit_exc), .commit_store(commit_store),
    .commit_eret(commit_eret),
`ifdef EXC_TLB_REFILL_VEC_EN
    .mem_tlb_refill(mem_tlb_refill),
`endif
    .mem_vaddr(mem_vaddr), .interrupt_flag(interrupt_flag),
    .allow_interrupt(allow_interrupt), .exl_set(exl_set), .use_special_iv(use_special_iv),
    .use_bootstrap_iv(use_bootstrap_iv), .ebase_address(ebase_address),
    .epc_address(epc_address), .redirect_ack(redirect_ack), .exp_en(exp_en),
    .exp_bd(exp_bd), .exp_badvaddr_en(exp_badvaddr_en), .exl_clean(exl_clean),
    .exp_code(exp_code), .exp_epc(exp_epc), .exp_badvaddr(exp_badvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Model: exception priority as an ordered table of flag -> code.
  int unsigned prio_code [11] = '{4, 2, 2, 10, 11, 12, 8, 9, 4, 5, 2};
  bit          m_busy = 0, m_pulse = 0, m_exl = 0, m_bven = 0, m_bd = 0;
  logic [4:0]  m_code = '0;
  logic [31:0] m_epc = '0, m_bad = '0, m_rpc = '0;

  always @(posedge clk) begin
    int hit;
    bit is_int;
    logic [31:0] base, off;
    m_pulse = 0; m_exl = 0; m_bven = 0;
    if (rst) begin
      m_busy = 0; m_code = '0; m_epc = '0; m_bad = '0; m_rpc = '0; m_bd = 0;
    end else if (m_busy) begin
      if (redirect_ack) m_busy = 0;
    end else if (commit_valid) begin
      is_int = allow_interrupt && (interrupt_flag != 8'h00);
      hit = -1;
      for (int i = 0; i < 11; i++)
        if (hit < 0 && commit_exc[i]) hit = i;
      base = use_bootstrap_iv ? 32'hBFC0_0200 : ebase_address;
      off  = 32'h180;
      if (is_int || hit >= 0) begin
        m_busy = 1; m_pulse = 1; m_bd = commit_bd;
        m_epc  = commit_pc - (commit_bd ? 32'd4 : 32'd0);
        m_bad  = mem_vaddr;
        if (is_int) begin
          m_code = 5'd0;
          if (use_special_iv) off = 32'h200;
        end else begin
          m_code = 5'(prio_code[hit]);
          if (hit == 10 && commit_store) m_code = 5'd3;
          m_bven = (hit <= 2) || (hit >= 8);
          if (hit <= 2) m_bad = commit_pc;
`ifdef EXC_TLB_REFILL_VEC_EN
          if (!exl_set && (hit == 1 || (hit == 10 && mem_tlb_refill))) off = 32'h0;
`endif
        end
        m_rpc = base + off;
      end else if (commit_eret) begin
        m_busy = 1; m_pulse = 1; m_exl = 1; m_bd = 0; m_code = 5'd0;
        m_epc = epc_address; m_bad = mem_vaddr; m_rpc = epc_address;
      end
    end
  end

  always @(negedge clk) begin
    chk("exp_en", 32'(exp_en), 32'(m_pulse));
    chk("flush", 32'(flush), 32'(m_pulse));
    chk("exl_clean", 32'(exl_clean), 32'(m_exl));
    chk("badvaddr_en", 32'(exp_badvaddr_en), 32'(m_bven));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_busy));
    chk("exp_code", 32'(exp_code), 32'(m_code));
    chk("exp_bd", 32'(exp_bd), 32'(m_bd));
    chk("exp_epc", exp_epc, m_epc);
    chk("exp_badvaddr", exp_badvaddr, m_bad);
    chk("redirect_pc", redirect_pc, m_rpc);
  end

  task automatic do_commit(input logic [31:0] pc, input logic bd, input logic [10:0] exc,
                           input logic store, input logic eret, input logic [31:0] va);
    commit_valid = 1; commit_pc = pc; commit_bd = bd; commit_exc = exc;
    commit_store = store; commit_eret = eret; mem_vaddr = va;
    @(negedge clk);
    commit_valid = 0; commit_exc = '0; commit_eret = 0; commit_store = 0;
  endtask

  task automatic ack_it();
    redirect_ack = 1;
    @(negedge clk);
    redirect_ack = 0;
    chk("ack_busy_low", 32'(busy), 32'd0);
  endtask

  int unsigned lit_codes [11] = '{4, 2, 2, 10, 11, 12, 8, 9, 4, 5, 2};
  int          en_cnt;
  logic [31:0] refill_vec;

  initial begin
    rst = 1; commit_valid = 0; commit_pc = '0; commit_bd = 0; commit_exc = '0;
    commit_store = 0; commit_eret = 0; mem_tlb_refill = 0; mem_vaddr = '0;
    interrupt_flag = '0; allow_interrupt = 0; exl_set = 0; use_special_iv = 0;
    use_bootstrap_iv = 0; ebase_address = 32'h8000_0000; epc_address = '0; redirect_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_exp_en", 32'(exp_en), 32'd0);
    rst = 0;
    @(negedge clk);

    // Overflow
    do_commit(32'h8000_1000, 0, 11'h020, 0, 0, 32'h0);
    chk("ov_en", 32'(exp_en), 32'd1);
    chk("ov_code", 32'(exp_code), 32'd12);
    chk("ov_epc", exp_epc, 32'h8000_1000);
    chk("ov_rpc", redirect_pc, 32'h8000_0180);
    ack_it();

    // Store address error in delay slot
    do_commit(32'h8000_2004, 1, 11'h200, 1, 0, 32'h0000_0003);
    chk("ades_code", 32'(exp_code), 32'd5);
    chk("ades_epc", exp_epc, 32'h8000_2000);
    chk("ades_bd", 32'(exp_bd), 32'd1);
    chk("ades_bven", 32'(exp_badvaddr_en), 32'd1);
    chk("ades_bad", exp_badvaddr, 32'h0000_0003);
    ack_it();

    // Interrupt beats RI, special vector
    interrupt_flag = 8'h04; allow_interrupt = 1; use_special_iv = 1;
    do_commit(32'h8000_0040, 0, 11'h008, 0, 0, 32'h0);
    chk("int_code", 32'(exp_code), 32'd0);
    chk("int_rpc", redirect_pc, 32'h8000_0200);
    interrupt_flag = '0; allow_interrupt = 0; use_special_iv = 0;
    ack_it();

    // ERET
    epc_address = 32'h8000_3000;
    do_commit(32'h8000_0100, 0, 11'h000, 0, 1, 32'h0);
    chk("eret_en", 32'(exp_en), 32'd1);
    chk("eret_exl", 32'(exl_clean), 32'd1);
    chk("eret_rpc", redirect_pc, 32'h8000_3000);
    ack_it();

    // Sys held while redirect is pending: only one exception may be reported
    en_cnt = 0;
    commit_valid = 1; commit_pc = 32'h8000_0500; commit_bd = 0; commit_exc = 11'h040;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (exp_en) en_cnt++;
      chk("hold_busy", 32'(busy), 32'd1);
    end
    chk("hold_one_exp_en", 32'(en_cnt), 32'd1);
    commit_valid = 0; commit_exc = '0;
    ack_it();

    // Priority table, one flag at a time
    for (int i = 0; i < 11; i++) begin
      do_commit(32'h8000_4000 + 32'(i * 4), 0, 11'(1 << i), (i == 9), 0, 32'h1234_5678);
      chk("prio_code", 32'(exp_code), 32'(lit_codes[i]));
      ack_it();
    end

    // TLB refill vector, EXL clear then set
`ifdef EXC_TLB_REFILL_VEC_EN
    refill_vec = 32'h8000_0000;
`else
    refill_vec = 32'h8000_0180;
`endif
    do_commit(32'h8000_6000, 0, 11'h002, 0, 0, 32'h0);
    chk("refill_rpc", redirect_pc, refill_vec);
    chk("refill_bad", exp_badvaddr, 32'h8000_6000);
    ack_it();
    exl_set = 1;
    do_commit(32'h8000_6000, 0, 11'h002, 0, 0, 32'h0);
    chk("refill_exl_rpc", redirect_pc, 32'h8000_0180);
    exl_set = 0;
    ack_it();

    // Store TLB miss through bootstrap vectors, ack on first redirect cycle
    use_bootstrap_iv = 1; mem_tlb_refill = 1; exl_set = 1;
    do_commit(32'h8000_7000, 0, 11'h400, 1, 0, 32'h0040_0000);
    chk("tlbs_code", 32'(exp_code), 32'd3);
    chk("tlbs_rpc", redirect_pc, 32'hBFC0_0380);
    use_bootstrap_iv = 0; mem_tlb_refill = 0; exl_set = 0;
    ack_it();

    // Delay slot at address 0 wraps EPC
    do_commit(32'h0000_0000, 1, 11'h080, 0, 0, 32'h0);
    chk("wrap_epc", exp_epc, 32'hFFFF_FFFC);
    ack_it();

    // Masked interrupt and idle exception flags are not events
    interrupt_flag = 8'hFF; allow_interrupt = 0;
    do_commit(32'h8000_8000, 0, 11'h000, 0, 0, 32'h0);
    chk("masked_int", 32'(exp_en), 32'd0);
    interrupt_flag = '0;
    commit_exc = 11'h7FF;
    @(negedge clk);
    chk("no_valid", 32'(busy), 32'd0);
    commit_exc = '0;

    // Reset abandons a pending redirect
    do_commit(32'h8000_9000, 0, 11'h040, 0, 0, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("rst_abandon_rv", 32'(redirect_valid), 32'd0);
    chk("rst_abandon_en", 32'(exp_en), 32'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 commit_valid  input  1  instruction at the commit point this cycle.
REQ-004 commit_pc  input  32  PC of the committing instruction.
REQ-005 commit_bd  input  1  committing instruction sits in a branch delay slot.
REQ-006 commit_exc  input  11  exception flags:
- [0] if_adel
- [1] if_tlb_refill
- [2] if_tlb_inv
- [3] ri
- [4] cpu
- [5] ov
- [6] sys
- [7] bp
- [8] mem_adel
- [9] mem_ades
- [10] mem_tlb_refill_or_inv; direction from commit_store.
REQ-007 commit_store  input  1  memory access is a store (selects TLBS/AdES).
REQ-008 commit_eret  input  1  committing instruction is ERET.
REQ-009 mem_vaddr  input  32  data virtual address of the committing instruction.
REQ-010 interrupt_flag  input  8  pending-and-enabled interrupt lines from CP0.
REQ-011 allow_interrupt  input  1  CP0 global interrupt enable (IE=1, EXL=0, ERL=0).
REQ-012 exl_set, use_special_iv, use_bootstrap_iv  input  1 each  CP0 Status/Cause vector controls.
REQ-013 ebase_address  input  32  CP0 EBase; epc_address input 32 CP0 EPC.
REQ-014 redirect_ack  input  1  fetch accepted redirect_pc.
REQ-015 exp_en, exp_bd, exp_badvaddr_en, exl_clean  output  1 each  CP0 exception update controls.
REQ-016 exp_code  output  5  ExcCode; exp_epc, exp_badvaddr output 32.
REQ-017 flush  output  1  kill all younger pipeline stages.
REQ-018 redirect_valid  output  1  redirect_pc is valid.
REQ-019 redirect_pc  output  32  new fetch address.
REQ-020 busy  output  1  commit stalled.

Function
REQ-021 Event detection and priority, when commit_valid=1 in IDLE:
- interrupt (allow_interrupt & |interrupt_flag), Int=0
- if_adel, AdEL=4
- if_tlb_*, TLBL=2
- ri, RI=10
- cpu, CpU=11
- ov, Ov=12
- sys, Sys=8
- bp, Bp=9
- mem_adel/ades, 4/5
- mem_tlb, TLBL=2 or TLBS=3
- eret
REQ-022 The accepted event is registered; exp_en and flush pulse exactly one cycle, the cycle after commit.
REQ-023 exp_epc = commit_bd ? commit_pc-4 : commit_pc (modulo 2^32); exp_bd = commit_bd.
REQ-024 exp_badvaddr_en=1 only for address/TLB codes:
- exp_badvaddr = commit_pc for fetch faults.
- exp_badvaddr = mem_vaddr for data faults.
- Otherwise exp_badvaddr_en=0 and exp_badvaddr=mem_vaddr.
REQ-025 Vector base = use_bootstrap_iv ? 0xBFC0_0200 : ebase_address.
REQ-026 Vector offset:
- 0x200 for Int with use_special_iv=1.
- 0x000 per REQ-041.
- Otherwise 0x180.
- redirect_pc = base + offset.
REQ-027 ERET: exp_en=1, exl_clean=1, exp_code=0, exp_bd=0, exp_epc=epc_address, exp_badvaddr_en=0, redirect_pc=epc_address; exl_clean=0 for all other events.
REQ-028 FSM states IDLE and REDIRECT:
- IDLE->REDIRECT on an accepted event.
- REDIRECT->IDLE on the cycle redirect_ack=1.
REQ-029 In REDIRECT:
- redirect_valid=1, busy=1.
- redirect_pc held stable.
- commit_valid ignored; no second exp_en.
REQ-030 redirect_valid and redirect_ack high in the same cycle completes the handshake; the next accepted event may occur the following cycle at the earliest.
REQ-031 exl_set sampled at commit, not at redirect.
REQ-032 commit_valid=0 or no event in IDLE: all pulse outputs 0, no state change.

Reset
REQ-033 On rst the FSM enters IDLE within one cycle.
REQ-034 On rst, exp_en, flush, redirect_valid, busy, exl_clean, exp_badvaddr_en = 0.
REQ-035 On rst, exp_code = 0, and exp_epc, exp_badvaddr, redirect_pc = 0x0000_0000.
REQ-036 rst during REDIRECT abandons the redirect without pulsing exp_en.

Configuration
REQ-040 The refill vector is controlled by macro EXC_TLB_REFILL_VEC_EN.
REQ-041 Defined: if_tlb_refill or mem TLB refill with exl_set=0 uses offset 0x000. Undefined: all TLB events use 0x180.
REQ-042 With EXC_TLB_REFILL_VEC_EN defined, refill versus invalid is signalled by a 1-bit input mem_tlb_refill; without the macro the port is absent.

Verification
REQ-050 ov at commit_pc=0x8000_1000, bd=0, ebase=0x8000_0000, no bootstrap:
- Next cycle exp_en=1, code=12, epc=0x8000_1000.
- redirect_pc=0x8000_0180.
REQ-051 mem_ades, store, bd=1, commit_pc=0x8000_2004, mem_vaddr=0x0000_0003:
- code=5, epc=0x8000_2000, exp_bd=1.
- badvaddr_en=1, badvaddr=0x0000_0003.
REQ-052 interrupt_flag=0x04, allow_interrupt=1, use_special_iv=1, ri also set:
- code=0 (interrupt wins).
- redirect_pc=0x8000_0200.
REQ-053 eret with epc_address=0x8000_3000:
- exp_en=1, exl_clean=1.
- redirect_pc=0x8000_3000.
REQ-054 Hold redirect_ack=0 for 5 cycles with commit_valid+sys each cycle:
- Exactly one exp_en.
- busy=1 throughout.
- Return to IDLE on ack.
REQ-055 Macro defined, if_tlb_refill, exl_set=0: redirect_pc=0x8000_0000. Same with exl_set=1: 0x8000_0180.
